ptp_b_sequencer: RTL and testbench

Frame controller for the byte/bit readout unpacker on the Manchester Baby output side. It drives the unpacker's reset, strobe, serialise and debug inputs so a full 160-bit snapshot is emitted as 20 bytes (parallel mode) or 160 single bits (serial mode). Each item is presented to the tile output logic with a valid/ack handshake. The block replaces free-running host toggling of the strobe with a deterministic, pointer-aligned sequence.

---
 rtl/ptp_b_sequencer.sv | 136 +++++++++++++
 tb/tb_ptp_b_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ptp_b_sequencer.sv
// Frame controller for the Baby readout unpacker: clears the pointer, then
// strobes out one item at a time behind a valid/ack handshake.
module ptp_b_sequencer #(
    parameter int unsigned ITEMS_PAR = 20,
    parameter int unsigned ITEMS_SER = 160,
    parameter int unsigned DIV_W     = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             serialise_i,
    input  logic             debug_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             ack_i,
    output logic             ptp_reset_o,
    output logic             ptp_control_o,
    output logic             ptp_serialise_o,
    output logic             ptp_debug_o,
    output logic             valid_o,
    output logic [7:0]       index_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned IDX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STROBE,
        S_SETTLE,
        S_PRESENT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ser_d, dbg_d;
    logic               abort_c;
    logic [IDX_W-1:0]   last_idx_c;
    logic               ptp_reset_d, ptp_control_d, valid_d, busy_d, done_d;

    assign last_idx_c = ptp_serialise_o ? IDX_W'(ITEMS_SER - 1) : IDX_W'(ITEMS_PAR - 1);

    // Next-state and next-output decode; outputs are registered from state_d.
    always_comb begin
        state_d = state_q;
        index_d = index_o;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ser_d   = ptp_serialise_o;
        dbg_d   = ptp_debug_o;
        abort_c = 1'b0;

        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            abort_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Abort outranks a simultaneous start.
                    if (start_i && !abort_i) begin
                        ser_d   = serialise_i;
                        dbg_d   = debug_i;
                        div_d   = div_i;
                        index_d = '0;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR:  state_d = S_STROBE;
                S_STROBE: state_d = S_SETTLE;
                S_SETTLE: state_d = S_PRESENT;
                S_PRESENT: begin
                    if (ack_i) begin
                        if (index_o == last_idx_c) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_o + IDX_W'(1);
                            if (div_q == '0) begin
                                state_d = S_STROBE;
                            end else begin
                                cnt_d   = div_q;
                                state_d = S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q <= DIV_W'(1)) state_d = S_STROBE;
                    else                    cnt_d   = cnt_q - DIV_W'(1);
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        ptp_reset_d   = (state_d == S_CLEAR) || abort_c;
        ptp_control_d = (state_d == S_STROBE);
        valid_d       = (state_d == S_PRESENT);
        done_d        = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            div_q           <= '0;
            index_o         <= '0;
            ptp_serialise_o <= 1'b0;
            ptp_debug_o     <= 1'b0;
            ptp_reset_o     <= 1'b0;
            ptp_control_o   <= 1'b0;
            valid_o         <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            div_q           <= div_d;
            index_o         <= index_d;
            ptp_serialise_o <= ser_d;
            ptp_debug_o     <= dbg_d;
            ptp_reset_o     <= ptp_reset_d;
            ptp_control_o   <= ptp_control_d;
            valid_o         <= valid_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
        end
    end

endmodule

// File: tb/tb_ptp_b_sequencer.sv
// Directed bench for ptp_b_sequencer: per-frame expected strobe/valid/reset
// schedules are queued at start and checked cycle by cycle.
module tb_ptp_b_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       serialise_i = 1'b0;
    logic       debug_i = 1'b0;
    logic [3:0] div_i = 4'd0;
    logic       ack_i = 1'b1;
    logic       ptp_reset_o, ptp_control_o, ptp_serialise_o, ptp_debug_o;
    logic       valid_o, busy_o, done_o;
    logic [7:0] index_o;

    int n_asrt = 0;
    int n_fail = 0;

    ptp_b_sequencer #(.ITEMS_PAR(20), .ITEMS_SER(160), .DIV_W(4)) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .serialise_i     (serialise_i),
        .debug_i         (debug_i),
        .div_i           (div_i),
        .ack_i           (ack_i),
        .ptp_reset_o     (ptp_reset_o),
        .ptp_control_o   (ptp_control_o),
        .ptp_serialise_o (ptp_serialise_o),
        .ptp_debug_o     (ptp_debug_o),
        .valid_o         (valid_o),
        .index_o         (index_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, "_reset"}, c, 32'(ptp_reset_o), 32'd0);
        chk({tag, "_control"}, c, 32'(ptp_control_o), 32'd0);
        chk({tag, "_serialise"}, c, 32'(ptp_serialise_o), 32'd0);
        chk({tag, "_debug"}, c, 32'(ptp_debug_o), 32'd0);
        chk({tag, "_valid"}, c, 32'(valid_o), 32'd0);
        chk({tag, "_index"}, c, 32'(index_o), 32'd0);
        chk({tag, "_busy"}, c, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, c, 32'(done_o), 32'd0);
    endtask

    // Cycle 0 is the cycle in which start_i is sampled. stall_k/abort_k/rst_k < 0 disables.
    task automatic run_frame(input logic ser, input logic dbg, input int dv, input int stall_k,
                             input int stall_len, input int abort_k, input int rst_k,
                             input bit start_noise);
        int vq_c[$];
        int vq_i[$];
        int sq[$];
        int rq[$];
        int n, tp, hold, done_t, busy_end, t_end, stall_t, abort_t, rst_t, last_idx;
        bit exp_b;
        n = ser ? 160 : 20;
        done_t = -1; stall_t = -1; abort_t = -1; rst_t = -1;
        busy_end = 0; last_idx = 0;
        rq.push_back(1);
        for (int k = 0; k < n; k++) begin
            tp = 4 + k * (3 + dv) + ((stall_k >= 0 && k > stall_k) ? stall_len : 0);
            sq.push_back(tp - 2);
            hold = (k == stall_k) ? stall_len : 0;
            if (k == stall_k) stall_t = tp;
            for (int h = 0; h <= hold; h++) begin
                vq_c.push_back(tp + h);
                vq_i.push_back(k);
            end
            last_idx = k;
            if (k == abort_k) begin
                abort_t = tp; busy_end = tp; rq.push_back(tp + 1);
                break;
            end
            if (k == rst_k) begin
                rst_t = tp + 1; busy_end = tp + 1;
                break;
            end
            if (k == n - 1) begin
                done_t = tp + 1; busy_end = tp + 1;
            end
        end
        t_end = busy_end + 2;

        for (int c = 0; c <= t_end; c++) begin
            start_i     = (c == 0) || (start_noise && c >= 10 && c <= 20);
            serialise_i = (c == 0) ? ser : ~ser;
            debug_i     = (c == 0) ? dbg : ~dbg;
            div_i       = (c == 0) ? 4'(dv) : 4'hf;
            ack_i       = !(stall_t >= 0 && c >= stall_t && c < stall_t + stall_len);
            abort_i     = (c == abort_t);

            exp_b = (vq_c.size() > 0 && vq_c[0] == c);
            chk("valid", c, 32'(valid_o), 32'(exp_b));
            if (exp_b) begin
                chk("index", c, 32'(index_o), 32'(vq_i[0]));
                void'(vq_c.pop_front());
                void'(vq_i.pop_front());
            end
            exp_b = (sq.size() > 0 && sq[0] == c);
            chk("control", c, 32'(ptp_control_o), 32'(exp_b));
            if (exp_b) void'(sq.pop_front());
            exp_b = (rq.size() > 0 && rq[0] == c);
            chk("ptp_reset", c, 32'(ptp_reset_o), 32'(exp_b));
            if (exp_b) void'(rq.pop_front());
            chk("done", c, 32'(done_o), 32'(c == done_t));
            chk("busy", c, 32'(busy_o), 32'(c >= 1 && c <= busy_end));
            if (c >= 1 && c <= busy_end) begin
                chk("serialise", c, 32'(ptp_serialise_o), 32'(ser));
                chk("debug", c, 32'(ptp_debug_o), 32'(dbg));
            end
            if (rst_k < 0 && c > busy_end)
                chk("index_hold", c, 32'(index_o), 32'(last_idx));

            if (c == rst_t) begin
                #2 reset_ni = 1'b0;
                #1 chk_all_zero("async_rst", c);
                #3 reset_ni = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0; abort_i = 1'b0; ack_i = 1'b1;
        serialise_i = 1'b0; debug_i = 1'b0; div_i = 4'd0;
    endtask

    initial begin
        reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 chk_all_zero("reset", 0);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        // Parallel, zero-wait ack, div 0: done at 62.
        run_frame(1'b0, 1'b0, 0, -1, 0, -1, -1, 1'b0);
        // Serial with debug: last valid 481, done 482.
        run_frame(1'b1, 1'b1, 0, -1, 0, -1, -1, 1'b0);
        // Parallel div 3 with start held high mid-frame: done 119.
        run_frame(1'b0, 1'b0, 3, -1, 0, -1, -1, 1'b1);
        // Backpressure on item 5 for 10 cycles.
        run_frame(1'b0, 1'b1, 0, 5, 10, -1, -1, 1'b0);
        // Abort in PRESENT of item 7, then a clean frame.
        run_frame(1'b0, 1'b0, 0, -1, 0, 7, -1, 1'b0);
        run_frame(1'b0, 1'b1, 1, -1, 0, -1, -1, 1'b0);
        // Async reset in the first GAP cycle after item 4, then a clean frame.
        run_frame(1'b0, 1'b1, 2, -1, 0, -1, 4, 1'b0);
        run_frame(1'b0, 1'b0, 0, -1, 0, -1, -1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
